// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone memory arbiter: FSM encoding,
// timeout counter width and a constant-foldable clog2.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  // Wide enough for the largest supported TIMEOUT_CYCLES (255).
  localparam int TMO_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational winner search: scans requests starting at ptr+1 (mod NUM_MASTERS)
// and returns the first hit as a one-hot vector plus its index.
module wb_arb_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] winner,
  output logic [IDX_W-1:0]       idx
);

  logic found;
  int   pos;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      pos = (int'(ptr) + 1 + k) % NUM_MASTERS;
      if (!found && req[pos]) begin
        found       = 1'b1;
        winner[pos] = 1'b1;
        idx         = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to 1-slave Wishbone arbiter with bus lock and slave-ack timeout.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (index 0 highest).
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_stall_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            o_grant
);

  localparam int IDX_W = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]       gidx_reg, gidx_next;
  logic [TMO_W-1:0]       tmo_reg, tmo_next;
  logic [NUM_MASTERS-1:0] pick_winner;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       ptr_sel;

  logic                  g_cyc, g_stb, g_we;
  logic [ADDR_WIDTH-1:0] g_adr;
  logic [DATA_WIDTH-1:0] g_dat;

  wb_arb_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req   (m_cyc_i),
    .ptr   (ptr_sel),
    .winner(pick_winner),
    .idx   (pick_idx)
  );

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_reg <= IDX_W'(NUM_MASTERS - 1);
    end else if (state_reg == ST_IDLE && (|m_cyc_i)) begin
      ptr_reg <= pick_idx;
    end
  end

  assign ptr_sel = ptr_reg;
`else
  // Searching from (N-1)+1 = 0 makes the picker a plain fixed-priority encoder.
  assign ptr_sel = IDX_W'(NUM_MASTERS - 1);
`endif

  assign g_cyc = m_cyc_i[gidx_reg];
  assign g_stb = m_stb_i[gidx_reg];
  assign g_we  = m_we_i[gidx_reg];
  assign g_adr = m_adr_i[int'(gidx_reg)*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_dat = m_dat_i[int'(gidx_reg)*DATA_WIDTH +: DATA_WIDTH];

  assign m_stall_o = m_cyc_i & ~grant_reg;
  assign m_dat_o   = s_dat_i;
  assign o_grant   = grant_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    tmo_next   = tmo_reg;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    m_ack_o    = '0;
    m_err_o    = '0;

    case (state_reg)
      ST_IDLE: begin
        tmo_next = '0;
        if (|m_cyc_i) begin
          grant_next = pick_winner;
          gidx_next  = pick_idx;
          state_next = ST_OWNED;
        end
      end

      ST_OWNED: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = g_we;
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        m_ack_o = grant_reg & {NUM_MASTERS{s_ack_i}};
        // Error fires during the TIMEOUT_CYCLES-th consecutive unacked strobe cycle.
        if (g_stb && !s_ack_i) begin
          if (tmo_reg == TMO_LAST) begin
            m_err_o    = grant_reg;
            tmo_next   = '0;
            state_next = ST_ABORT;
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
        end else begin
          tmo_next = '0;
        end
        if (state_next == ST_OWNED && !g_cyc) begin
          grant_next = '0;
          state_next = ST_IDLE;
        end
      end

      ST_ABORT: begin
        if (!g_cyc) begin
          grant_next = '0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        grant_next = '0;
        tmo_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (2 masters, TIMEOUT_CYCLES=4); expectations
// follow the policy selected by WB_ARB_ROUND_ROBIN_EN.
module tb_wb_mem_arbiter;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic [NM-1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [DW-1:0] m_dat_o;
  logic [NM-1:0] m_ack_o, m_err_o, m_stall_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [NM-1:0] o_grant;

  int tests_run;
  int tests_failed;

  wb_mem_arbiter #(
    .NUM_MASTERS   (NM),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_cyc_i  (m_cyc_i),
    .m_stb_i  (m_stb_i),
    .m_we_i   (m_we_i),
    .m_adr_i  (m_adr_i),
    .m_dat_i  (m_dat_i),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_stall_o(m_stall_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .o_grant  (o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NM-1:0] exp_g;
    tests_run    = 0;
    tests_failed = 0;
    rst     = 1'b0;
    m_cyc_i = 2'b11;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;

    // Reset state with both masters already requesting
    #2;
    check_eq("rst_grant", 64'(o_grant), 64'h0);
    check_eq("rst_stall", 64'(m_stall_o), 64'h3);
    check_eq("rst_scyc",  64'(s_cyc_o), 64'h0);
    check_eq("rst_ack",   64'(m_ack_o), 64'h0);
    m_cyc_i = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // Single master write from master 1
    $display("[TB] txn: master1 write 0x10 <= 0xDEADBEEF");
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
    m_adr_i[AW +: AW] = 32'h10;
    m_dat_i[DW +: DW] = 32'hDEADBEEF;
    #1;
    check_eq("w_pre_grant", 64'(o_grant), 64'h0);
    check_eq("w_pre_stall", 64'(m_stall_o), 64'h2);
    check_eq("w_pre_scyc",  64'(s_cyc_o), 64'h0);
    step();
    check_eq("w_grant", 64'(o_grant), 64'h2);
    check_eq("w_scyc",  64'(s_cyc_o), 64'h1);
    check_eq("w_swe",   64'(s_we_o), 64'h1);
    check_eq("w_sadr",  64'(s_adr_o), 64'h10);
    check_eq("w_sdat",  64'(s_dat_o), 64'hDEADBEEF);
    check_eq("w_stall", 64'(m_stall_o), 64'h0);
    check_eq("w_noack", 64'(m_ack_o), 64'h0);
    // ack arrives in the same cycle the master drops cyc
    s_ack_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    #1;
    check_eq("w_ack", 64'(m_ack_o), 64'h2);
    step();
    s_ack_i = 1'b0;
    #1;
    check_eq("w_release", 64'(o_grant), 64'h0);
    check_eq("w_idle_scyc", 64'(s_cyc_o), 64'h0);

    // Contention plus locked burst of three strobes by master 0
    $display("[TB] txn: master0 locked 3-strobe read burst, master1 waiting");
    m_cyc_i = 2'b11; m_stb_i = 2'b11; m_we_i = '0;
    m_adr_i[0 +: AW]  = 32'h100;
    m_adr_i[AW +: AW] = 32'h200;
    step();
    check_eq("c_grant", 64'(o_grant), 64'h1);
    check_eq("c_stall", 64'(m_stall_o), 64'h2);
    for (int k = 0; k < 3; k++) begin
      m_adr_i[0 +: AW] = 32'h100 + 32'(4 * k);
      s_dat_i = 32'hA000 + 32'(k);
      s_ack_i = 1'b1;
      #1;
      check_eq("lock_ack",   64'(m_ack_o), 64'h1);
      check_eq("lock_stall", 64'(m_stall_o), 64'h2);
      check_eq("lock_adr",   64'(s_adr_o), 64'h100 + 64'(4 * k));
      check_eq("lock_rdat",  64'(m_dat_o), 64'hA000 + 64'(k));
      step();
    end
    m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
    step();
    check_eq("c_idle_grant", 64'(o_grant), 64'h0);
    check_eq("c_idle_stall", 64'(m_stall_o), 64'h2);
    step();
    check_eq("c_grant1", 64'(o_grant), 64'h2);
    check_eq("c_adr1",   64'(s_adr_o), 64'h200);
    m_cyc_i = '0; m_stb_i = '0;
    step();

    // Both masters request continuously with one-strobe cycles
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      step();
      $display("[TB] txn: continuous request round %0d grant=%b", k, o_grant);
      check_eq("alt_grant", 64'(o_grant), 64'(exp_g));
      s_ack_i = 1'b1;
      m_cyc_i = 2'b11 & ~exp_g; m_stb_i = 2'b11 & ~exp_g;
      #1;
      check_eq("alt_ack", 64'(m_ack_o), 64'(exp_g));
      step();
      s_ack_i = 1'b0;
    end
    m_cyc_i = '0; m_stb_i = '0;
    step();

    // Slave never acks: timeout and abort
    $display("[TB] txn: master0 read with silent slave");
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_eq("tmo_err", 64'(m_err_o), (c == 4) ? 64'h1 : 64'h0);
      check_eq("tmo_stb", 64'(s_stb_o), 64'h1);
      step();
    end
    check_eq("abort_grant", 64'(o_grant), 64'h1);
    check_eq("abort_stb",   64'(s_stb_o), 64'h0);
    check_eq("abort_cyc",   64'(s_cyc_o), 64'h0);
    check_eq("abort_err",   64'(m_err_o), 64'h0);
    s_ack_i = 1'b1;
    #1;
    check_eq("abort_noack", 64'(m_ack_o), 64'h0);
    step();
    check_eq("abort_hold", 64'(o_grant), 64'h1);
    m_cyc_i = '0; m_stb_i = '0;
    step();
    check_eq("abort_release", 64'(o_grant), 64'h0);
    check_eq("idle_noack",    64'(m_ack_o), 64'h0);
    s_ack_i = 1'b0;

    // Reset in the middle of a read
    $display("[TB] txn: master1 read interrupted by reset");
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = '0;
    m_adr_i[0 +: AW]  = 32'h300;
    m_adr_i[AW +: AW] = 32'h40;
    step();
    check_eq("mr_grant", 64'(o_grant), 64'h2);
    s_ack_i = 1'b1; s_dat_i = 32'h12345678;
    #1 rst = 1'b0;
    #1;
    check_eq("mr_grant0", 64'(o_grant), 64'h0);
    check_eq("mr_noack",  64'(m_ack_o), 64'h0);
    check_eq("mr_noerr",  64'(m_err_o), 64'h0);
    check_eq("mr_scyc",   64'(s_cyc_o), 64'h0);
    check_eq("mr_sadr",   64'(s_adr_o), 64'h0);
    check_eq("mr_stall",  64'(m_stall_o), 64'h2);
    s_ack_i = 1'b0;
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    #1 rst = 1'b1;
    step();
    check_eq("post_rst_grant", 64'(o_grant), 64'h1);
    check_eq("post_rst_adr",   64'(s_adr_o), 64'h300);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters (range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address bus width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, cycles without slave ack before abort (range 2..255).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports m_cyc_i, m_stb_i, m_we_i  input  NUM_MASTERS  per-master cycle, strobe, write enable.
REQ-008 SHALL have port m_adr_i  input  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i.
REQ-009 SHALL have port m_dat_i  input  NUM_MASTERS*DATA_WIDTH  packed write data.
REQ-010 SHALL have port m_dat_o  output  DATA_WIDTH  slave read data broadcast to all masters.
REQ-011 SHALL have ports m_ack_o, m_err_o, m_stall_o  output  NUM_MASTERS  per-master ack, abort error, stall.
REQ-012 SHALL have ports s_cyc_o, s_stb_o, s_we_o  output  1  slave cycle, strobe, write enable.
REQ-013 SHALL have ports s_adr_o  output  ADDR_WIDTH and s_dat_o  output  DATA_WIDTH  slave address and write data.
REQ-014 SHALL have ports s_dat_i  input  DATA_WIDTH and s_ack_i  input  1  slave read data and ack.
REQ-015 SHALL have port o_grant  output  NUM_MASTERS  registered one-hot grant vector.

Function
REQ-016 SHALL implement FSM states IDLE, OWNED, ABORT.
REQ-017 IDLE: if any m_cyc_i set, SHALL pick winner per REQ-023/REQ-032, register one-hot o_grant, enter OWNED next edge; arbitration latency exactly 1 cycle.
REQ-018 OWNED: SHALL drive s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o combinationally from granted master; m_ack_o[g] = s_ack_i.
REQ-019 OWNED: grant SHALL be held while m_cyc_i[g] stays high (bus lock across multiple strobes); on m_cyc_i[g] low SHALL clear o_grant and return to IDLE next edge.
REQ-020 SHALL assert m_stall_o[i] = m_cyc_i[i] & ~o_grant[i] combinationally; non-granted masters SHALL see m_ack_o = 0 and m_err_o = 0.
REQ-021 Timeout counter SHALL increment each OWNED cycle with s_stb_o high and s_ack_i low, clear on s_ack_i or strobe low; reaching TIMEOUT_CYCLES SHALL pulse m_err_o[g] one cycle and enter ABORT.
REQ-022 ABORT: s_cyc_o and s_stb_o SHALL be 0; grant held until m_cyc_i[g] low, then IDLE.
REQ-023 Default arbitration SHALL be fixed priority, index 0 highest.
REQ-024 s_ack_i in same cycle as m_cyc_i[g] falling SHALL still be forwarded to m_ack_o[g]; grant then releases at that edge.
REQ-025 s_ack_i outside OWNED SHALL be ignored (no m_ack_o).
REQ-026 Slave outputs SHALL be all-zero when no grant is held.

Reset
REQ-027 rst low SHALL immediately force state IDLE, o_grant 0, timeout counter 0, round-robin pointer NUM_MASTERS-1.
REQ-028 During reset all m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o SHALL be 0, s_adr_o/s_dat_o 0, m_stall_o = m_cyc_i.
REQ-029 Reset mid-transaction SHALL abandon it with no ack or err to any master.

Configuration
REQ-030 Macro WB_ARB_ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-031 Without it: fixed priority per REQ-023; no pointer register synthesised.
REQ-032 With it: search starts at pointer+1 modulo NUM_MASTERS; pointer updated to winner index on each grant.

Structure
REQ-033 Shared package wb_arb_pkg SHALL hold FSM state encoding, counter width constant, and clog2 function.
REQ-034 Winner selection SHALL be sub-module wb_arb_picker (request vector, pointer in; one-hot winner, index out), purely combinational.

Verification
REQ-035 Single master: master 1 cyc/stb write adr 0x10 dat 0xDEADBEEF -> o_grant=2'b10 one cycle later, slave sees write, m_ack_o[1] on s_ack_i.
REQ-036 Simultaneous request masters 0 and 1, fixed priority -> master 0 granted, m_stall_o[1]=1 until master 0 drops cyc, master 1 granted next arbitration.
REQ-037 WB_ARB_ROUND_ROBIN_EN, both masters requesting continuously with one-strobe cycles -> grants alternate 0,1,0,1.
REQ-038 Slave never acks, TIMEOUT_CYCLES=4 -> m_err_o[g] pulses after 4 stalled cycles, s_stb_o drops, grant held until cyc low.
REQ-039 Lock: master 0 issues 3 back-to-back strobes under one cyc while master 1 requests -> master 1 stalled throughout, no interleave.
REQ-040 rst asserted mid-read -> outputs zero asynchronously, no ack; after release master 0 wins first under both policies.
